reflet_bus_bridge: RTL and testbench
====================================

# reflet_bus_bridge

Byte-stream-to-system-bus bridge: a second bus initiator alongside the CPU. It decodes command frames arriving as bytes (typically from a UART receiver), stalls the CPU, performs one 16-bit word read or write on the system bus, and returns a reply byte stream. It is used for host-driven loading and inspection of data RAM and peripherals. The top level multiplexes `bus_*` against the CPU bus using `bus_owned`.

## Interface
- `READ_LATENCY`, 1: cycles from address presentation to valid `bus_data_in` (1 for synchronous ROM/RAM).
- `TIMEOUT_CYCLES`, 100000: inter-byte idle limit. Only used when the timeout feature is compiled in.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rx_data` in 8: incoming command byte.
- `rx_valid` in 1: `rx_data` valid; byte consumed when `rx_valid & rx_ready`.
- `rx_ready` out 1: bridge can accept a byte.
- `tx_data` out 8: reply byte.
- `tx_valid` out 1: `tx_data` valid; held stable until `tx_ready`.
- `tx_ready` in 1: downstream accepts the reply byte.
- `cpu_enable` out 1: low while the bridge holds the bus; ANDed into the CPU enable at top level.
- `bus_owned` out 1: bridge drives the system bus; selects bridge `bus_*` over CPU signals.
- `bus_addr` out 16: word address, bit 0 always 0.
- `bus_data_out` out 16: write data.
- `bus_write_en` out 1: single-cycle write strobe.
- `bus_data_in` in 16: OR-combined read data from all responders.

## Operation
- Frames use big-endian fields:
  - Write: `0x57 'W'`, addr_hi, addr_lo, data_hi, data_lo → reply `0x06`.
  - Read: `0x52 'R'`, addr_hi, addr_lo → reply data_hi, data_lo.
- Any other opcode byte → reply `0x15`; the FSM returns to IDLE without consuming further bytes.
- FSM states: IDLE → ADDR_HI → ADDR_LO → (write: DATA_HI → DATA_LO) → HOLD → ACCESS → (read: WAIT) → REPLY → IDLE.
- `rx_ready` is 1 only in IDLE, ADDR_HI, ADDR_LO, DATA_HI and DATA_LO.
- HOLD: `cpu_enable`=0 for one cycle so the CPU completes its current cycle; `bus_owned` still 0.
- ACCESS: `bus_owned`=1 and `bus_addr`={addr[15:1],1'b0}.
  - Write: `bus_write_en`=1 for exactly this cycle, then go to REPLY.
  - Read: `bus_write_en`=0; address held through WAIT for READ_LATENCY cycles; `bus_data_in` is captured on the last WAIT cycle.
- REPLY: `cpu_enable`=1 and `bus_owned`=0 on entry. Reply bytes are presented one at a time, each held until `tx_ready`.
- The CPU runs during frame reception and during the reply; it is stalled only in HOLD, ACCESS and WAIT.
- Reset outputs: `rx_ready`=1, `tx_valid`=0, `tx_data`=0, `cpu_enable`=1, `bus_owned`=0, `bus_addr`=0, `bus_data_out`=0, `bus_write_en`=0.
- Reset mid-access: the bus is released immediately, with no partial write strobe after reset deassertion.

## Timing
- Write frame: the CPU is stalled for exactly 2 cycles (HOLD, ACCESS). `tx_valid` rises the cycle after ACCESS.
- Read frame: the CPU is stalled for 2+READ_LATENCY cycles. data_hi appears on `tx_valid` the cycle after capture.
- `bus_write_en` never coincides with `bus_owned`=0.
- `rx_valid` while `rx_ready`=0: the byte is ignored (dropped). The sender must wait for the reply before starting the next frame.
- `tx_ready` may be held high permanently: each reply byte then lasts 1 cycle.
- An address of 0xFFFF is accessed as 0xFFFE.

## Configuration
- `REFLET_BUS_BRIDGE_TIMEOUT_EN` defined:
  - A counter reloads on every accepted byte.
  - If TIMEOUT_CYCLES elapse in ADDR_HI through DATA_LO without a byte, the frame is aborted, `0x15` is sent and the FSM returns to IDLE.
  - No bus access occurs on abort.
- Undefined: no counter. A partial frame waits indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Shared package `reflet_bus_bridge_pkg`:
  - FSM state enum.
  - Opcode constants `OP_WRITE`=0x57 and `OP_READ`=0x52.
  - Reply constants `ACK`=0x06 and `NAK`=0x15.
- One sub-module, `reflet_bus_bridge_timeout`: the reloadable down-counter with an `expired` pulse, instantiated only under the macro.
- Frame decode, bus sequencing and reply serialisation stay in the top module.

## Test plan
- Write: bytes 57 80 10 BE EF with `tx_ready`=1 → one cycle with `bus_write_en`=1, `bus_addr`=0x8010, `bus_data_out`=0xBEEF; `cpu_enable` low exactly 2 cycles; reply 0x06.
- Read with READ_LATENCY=1: bytes 52 80 10, responder returns 0x1234 one cycle after address → replies 0x12 then 0x34; `bus_write_en` never asserted.
- Bad opcode: byte 0x41 → reply 0x15; no `bus_owned`; the next frame 52 80 00 is processed normally.
- Backpressure: read frame with `tx_ready` low 20 cycles → `tx_data`=data_hi held stable, `cpu_enable`=1 during the wait, then data_lo after the handshake.
- Odd address and reset: write 57 FF FF 00 01 → `bus_addr`=0xFFFE. Then assert `reset` during ACCESS of the next write → all outputs at reset values within the same cycle, and no strobe after release.
- With `REFLET_BUS_BRIDGE_TIMEOUT_EN` and TIMEOUT_CYCLES=50: bytes 57 80 then silence → after 50 cycles reply 0x15, FSM in IDLE, no bus access.

Source files
------------

// File: rtl/reflet_bus_bridge_pkg.sv
// Shared types and byte constants for the reflet byte-stream bus bridge.
package reflet_bus_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_HOLD    = 4'd5,
    ST_ACCESS  = 4'd6,
    ST_WAIT    = 4'd7,
    ST_REPLY   = 4'd8
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  // States in which a command byte may be consumed.
  function automatic logic accepts_rx(input state_t s);
    case (s)
      ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: accepts_rx = 1'b1;
      default: accepts_rx = 1'b0;
    endcase
  endfunction

  // States in which the CPU is held off the bus.
  function automatic logic stalls_cpu(input state_t s);
    case (s)
      ST_HOLD, ST_ACCESS, ST_WAIT: stalls_cpu = 1'b1;
      default: stalls_cpu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reflet_bus_bridge_timeout.sv
// Reloadable inter-byte idle counter; pulses expired after TIMEOUT_CYCLES idle cycles.
// Only instantiated when REFLET_BUS_BRIDGE_TIMEOUT_EN is defined.
module reflet_bus_bridge_timeout
  import reflet_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_r;

  // Down-counter, parked at the load value whenever no frame is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= LOAD_VAL;
    end else if (reload || !run) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = run & ~reload & (cnt_r == CNT_W'(1));

endmodule

// File: rtl/reflet_bus_bridge.sv
// Byte-stream to system-bus bridge: decodes W/R frames, stalls the CPU, does one word access, replies.
// Optional inter-byte abort compiled in with REFLET_BUS_BRIDGE_TIMEOUT_EN.
module reflet_bus_bridge
  import reflet_bus_bridge_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_enable,
  output logic        bus_owned,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_data_out,
  output logic        bus_write_en,
  input  logic [15:0] bus_data_in
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  state_t state_r, next_state_s;
  logic              is_write_r;
  logic [15:0]       addr_r;
  logic [15:0]       wdata_r;
  logic [7:0]        data_lo_r;
  logic              reply_more_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              rx_ready_r, tx_valid_r, cpu_enable_r, bus_owned_r, bus_write_en_r;
  logic [7:0]        tx_data_r;
  logic [15:0]       bus_addr_r, bus_data_out_r;
  logic              rx_fire_s, tx_fire_s, expired_s;

  assign rx_fire_s = rx_valid & rx_ready_r;
  assign tx_fire_s = tx_valid_r & tx_ready;

`ifdef REFLET_BUS_BRIDGE_TIMEOUT_EN
  logic frame_active_s;
  assign frame_active_s = (state_r != ST_IDLE) && accepts_rx(state_r);

  reflet_bus_bridge_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .run     (frame_active_s),
    .reload  (rx_fire_s),
    .expired (expired_s)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expired_s = 1'b0;
`endif

  // Next-state logic for frame decode, bus sequencing and reply.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) next_state_s = ST_ADDR_HI;
          else next_state_s = ST_REPLY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADDR_HI: begin
        if (rx_fire_s) next_state_s = ST_ADDR_LO;
        else if (expired_s) next_state_s = ST_REPLY;
        else next_state_s = ST_ADDR_HI;
      end
      ST_ADDR_LO: begin
        if (rx_fire_s) next_state_s = is_write_r ? ST_DATA_HI : ST_HOLD;
        else if (expired_s) next_state_s = ST_REPLY;
        else next_state_s = ST_ADDR_LO;
      end
      ST_DATA_HI: begin
        if (rx_fire_s) next_state_s = ST_DATA_LO;
        else if (expired_s) next_state_s = ST_REPLY;
        else next_state_s = ST_DATA_HI;
      end
      ST_DATA_LO: begin
        if (rx_fire_s) next_state_s = ST_HOLD;
        else if (expired_s) next_state_s = ST_REPLY;
        else next_state_s = ST_DATA_LO;
      end
      ST_HOLD:   next_state_s = ST_ACCESS;
      ST_ACCESS: next_state_s = is_write_r ? ST_REPLY : ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) next_state_s = ST_REPLY;
        else next_state_s = ST_WAIT;
      end
      ST_REPLY: begin
        if (tx_fire_s && !reply_more_r) next_state_s = ST_IDLE;
        else next_state_s = ST_REPLY;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, frame capture and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      is_write_r     <= 1'b0;
      addr_r         <= 16'h0000;
      wdata_r        <= 16'h0000;
      data_lo_r      <= 8'h00;
      reply_more_r   <= 1'b0;
      wait_cnt_r     <= {WAIT_W{1'b0}};
      rx_ready_r     <= 1'b1;
      tx_valid_r     <= 1'b0;
      tx_data_r      <= 8'h00;
      cpu_enable_r   <= 1'b1;
      bus_owned_r    <= 1'b0;
      bus_addr_r     <= 16'h0000;
      bus_data_out_r <= 16'h0000;
      bus_write_en_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      rx_ready_r     <= accepts_rx(next_state_s);
      cpu_enable_r   <= ~stalls_cpu(next_state_s);
      bus_owned_r    <= (next_state_s == ST_ACCESS) || (next_state_s == ST_WAIT);
      bus_write_en_r <= (next_state_s == ST_ACCESS) && is_write_r;
      tx_valid_r     <= (next_state_s == ST_REPLY);

      if (rx_fire_s) begin
        case (state_r)
          ST_IDLE:    is_write_r    <= (rx_data == OP_WRITE);
          ST_ADDR_HI: addr_r[15:8]  <= rx_data;
          ST_ADDR_LO: addr_r[7:0]   <= rx_data;
          ST_DATA_HI: wdata_r[15:8] <= rx_data;
          ST_DATA_LO: wdata_r[7:0]  <= rx_data;
          default:    addr_r        <= addr_r;
        endcase
      end

      // Word-aligned address is latched as the bus is taken.
      if (state_r == ST_HOLD) begin
        bus_addr_r <= {addr_r[15:1], 1'b0};
        if (is_write_r) bus_data_out_r <= wdata_r;
      end

      if (state_r == ST_ACCESS) wait_cnt_r <= {WAIT_W{1'b0}};
      else if (state_r == ST_WAIT) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);

      if (next_state_s == ST_REPLY && state_r != ST_REPLY) begin
        case (state_r)
          ST_ACCESS: begin
            tx_data_r    <= ACK;
            reply_more_r <= 1'b0;
          end
          ST_WAIT: begin
            tx_data_r    <= bus_data_in[15:8];
            data_lo_r    <= bus_data_in[7:0];
            reply_more_r <= 1'b1;
          end
          default: begin
            tx_data_r    <= NAK;
            reply_more_r <= 1'b0;
          end
        endcase
      end else if (state_r == ST_REPLY && tx_fire_s && reply_more_r) begin
        tx_data_r    <= data_lo_r;
        reply_more_r <= 1'b0;
      end
    end
  end

  assign rx_ready     = rx_ready_r;
  assign tx_valid     = tx_valid_r;
  assign tx_data      = tx_data_r;
  assign cpu_enable   = cpu_enable_r;
  assign bus_owned    = bus_owned_r;
  assign bus_addr     = bus_addr_r;
  assign bus_data_out = bus_data_out_r;
  assign bus_write_en = bus_write_en_r;

endmodule

// File: tb/tb_reflet_bus_bridge.sv
// Directed, table-driven bench for reflet_bus_bridge (READ_LATENCY=1, TIMEOUT_CYCLES=50).
// The abort sequence runs only when REFLET_BUS_BRIDGE_TIMEOUT_EN is defined.
module tb_reflet_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        cpu_enable;
  logic        bus_owned;
  logic [15:0] bus_addr;
  logic [15:0] bus_data_out;
  logic        bus_write_en;
  logic [15:0] bus_data_in;

  logic [15:0] resp_word = 16'h0000;
  logic [15:0] resp_q = 16'h0000;

  int checks = 0;
  int errors = 0;

  int cyc = 0, stall_cnt = 0, owned_cnt = 0, strobe_cnt = 0, bad_strobe_cnt = 0;
  int owned_last = 0, tx_rise = 0;
  logic [15:0] owned_addr = 16'h0000, strobe_addr = 16'h0000, strobe_data = 16'h0000;
  logic tx_prev = 1'b0;

  reflet_bus_bridge #(.READ_LATENCY(1), .TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .cpu_enable   (cpu_enable),
    .bus_owned    (bus_owned),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_write_en (bus_write_en),
    .bus_data_in  (bus_data_in)
  );

  always #5 clk = ~clk;

  // Synchronous responder: data valid one cycle after the address is presented.
  always @(posedge clk) resp_q <= (bus_owned && !bus_write_en) ? resp_word : 16'h0000;
  assign bus_data_in = resp_q;

  // Bus activity monitor sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    tx_prev <= tx_valid;
    if (!reset) begin
      if (!cpu_enable) stall_cnt <= stall_cnt + 1;
      if (bus_owned) begin
        owned_cnt  <= owned_cnt + 1;
        owned_addr <= bus_addr;
        owned_last <= cyc;
      end
      if (bus_write_en) begin
        strobe_cnt  <= strobe_cnt + 1;
        strobe_addr <= bus_addr;
        strobe_data <= bus_data_out;
        if (!bus_owned) bad_strobe_cnt <= bad_strobe_cnt + 1;
      end
      if (tx_valid && !tx_prev) tx_rise <= cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_cpu_enable"}, 32'(cpu_enable), 32'd1);
    chk({tag, "_bus_owned"}, 32'(bus_owned), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_data_out"}, 32'(bus_data_out), 32'd0);
    chk({tag, "_bus_write_en"}, 32'(bus_write_en), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Counts reply handshakes over a fixed window, keeping the first two bytes.
  task automatic collect(output logic [7:0] b0, output logic [7:0] b1, output int got);
    got = 0;
    b0  = 8'hxx;
    b1  = 8'hxx;
    for (int i = 0; i < 60; i++) begin
      if (tx_valid && tx_ready) begin
        if (got == 0) b0 = tx_data;
        else if (got == 1) b1 = tx_data;
        got++;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [39:0] frame;
    int          nb;
    logic [15:0] resp;
    int          nr;
    logic [7:0]  r0;
    logic [7:0]  r1;
    int          strobes;
    int          stall;
    int          owned;
    logic [15:0] addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] b0, b1;
    int got, s0, o0, w0, n;
    string t;

    vecs[0] = '{40'h57801_0BEEF, 5, 16'h0000, 1, 8'h06, 8'h00, 1, 2, 1, 16'h8010, 16'hBEEF};
    vecs[1] = '{40'h5280100000, 3, 16'h1234, 2, 8'h12, 8'h34, 0, 3, 2, 16'h8010, 16'h0000};
    vecs[2] = '{40'h4100000000, 1, 16'h0000, 1, 8'h15, 8'h00, 0, 0, 0, 16'h0000, 16'h0000};
    vecs[3] = '{40'h5280000000, 3, 16'hABCD, 2, 8'hAB, 8'hCD, 0, 3, 2, 16'h8000, 16'h0000};
    vecs[4] = '{40'h57FFFF0001, 5, 16'h0000, 1, 8'h06, 8'h00, 1, 2, 1, 16'hFFFE, 16'h0001};
    vecs[5] = '{40'h5200030000, 3, 16'h00FF, 2, 8'h00, 8'hFF, 0, 3, 2, 16'h0002, 16'h0000};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      t = $sformatf("v%0d", i);
      resp_word = vecs[i].resp;
      s0 = stall_cnt; o0 = owned_cnt; w0 = strobe_cnt;
      for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].frame[39 - 8*k -: 8]);
      collect(b0, b1, got);
      chk({t, "_reply_count"}, 32'(got), 32'(vecs[i].nr));
      chk({t, "_reply0"}, 32'(b0), 32'(vecs[i].r0));
      if (vecs[i].nr == 2) chk({t, "_reply1"}, 32'(b1), 32'(vecs[i].r1));
      chk({t, "_stall_cycles"}, 32'(stall_cnt - s0), 32'(vecs[i].stall));
      chk({t, "_owned_cycles"}, 32'(owned_cnt - o0), 32'(vecs[i].owned));
      chk({t, "_strobes"}, 32'(strobe_cnt - w0), 32'(vecs[i].strobes));
      if (vecs[i].owned > 0) begin
        chk({t, "_addr"}, 32'(owned_addr), 32'(vecs[i].addr));
        chk({t, "_tx_rise_after_access"}, 32'(tx_rise - owned_last), 32'd1);
      end
      if (vecs[i].strobes > 0) begin
        chk({t, "_strobe_addr"}, 32'(strobe_addr), 32'(vecs[i].addr));
        chk({t, "_strobe_data"}, 32'(strobe_data), 32'(vecs[i].wdata));
      end
      chk({t, "_strobe_without_owned"}, 32'(bad_strobe_cnt), 32'd0);
    end

    // Backpressure: first reply byte must hold while tx_ready is low.
    resp_word = 16'hC3A5;
    tx_ready  = 1'b0;
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reply_seen", 32'(tx_valid), 32'd1);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid || tx_data !== 8'hC3 || !cpu_enable || rx_ready) got++;
      @(negedge clk);
    end
    chk("bp_hold_violations", 32'(got), 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", 32'(tx_valid), 32'd1);
    chk("bp_second_byte", 32'(tx_data), 32'hA5);
    @(negedge clk);
    chk("bp_done_valid", 32'(tx_valid), 32'd0);
    chk("bp_done_rx_ready", 32'(rx_ready), 32'd1);

    // Reset asserted during ACCESS of a write.
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    n = 0;
    while (!bus_owned && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_access", 32'(bus_write_en), 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    w0 = strobe_cnt; o0 = owned_cnt;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_strobe", 32'(strobe_cnt - w0), 32'd0);
    chk("midrst_no_owned", 32'(owned_cnt - o0), 32'd0);
    chk("midrst_no_reply", 32'(tx_valid), 32'd0);

`ifdef REFLET_BUS_BRIDGE_TIMEOUT_EN
    // Partial frame then silence: NAK after the idle limit, no bus access.
    o0 = owned_cnt;
    send_byte(8'h57); send_byte(8'h80);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_idle_cycles", 32'(n), 32'd50);
    chk("to_reply", 32'(tx_data), 32'h15);
    chk("to_no_owned", 32'(owned_cnt - o0), 32'd0);
    repeat (2) @(negedge clk);
    chk("to_back_idle", 32'(rx_ready), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
